// File: rtl/counter_cmd_seq_pkg.sv
// counter_cmd_seq_pkg
//   Shared definitions for the counter command sequencer and the up/down
//   loadable counter it drives: default data/length widths, command opcodes
//   and sequencer state encodings.
package counter_cmd_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_UP   = 2'b10,
    CMD_DOWN = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_LOAD = 2'b01,
    SEQ_RUN  = 2'b10,
    SEQ_DONE = 2'b11
  } seq_state_e;

endpackage

// File: rtl/counter_cmd_seq_if.sv
// counter_cmd_seq_if
//   Command channel into the counter sequencer (valid/ready handshake).
//   Signals:
//     cmd_valid  command present (master -> slave)
//     cmd_ready  sequencer can accept (slave -> master)
//     cmd_op     00 HOLD, 01 LOAD, 10 UP, 11 DOWN
//     cmd_data   load value, LOAD only
//     cmd_len    step/cycle count, HOLD/UP/DOWN
interface counter_cmd_seq_if
  import counter_cmd_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq
//   Sequences LOAD/UP/DOWN/HOLD commands onto the pins of an up/down
//   loadable counter, one command at a time, and reports completion.
//   Optional build macro: SAT_STOP_EN -- stop an UP run when the counter
//   reports max_count, or a DOWN run when it reports zero, instead of wrapping.
//   Ports:
//     clk, rst_n     clock (posedge) and synchronous active-low reset
//     cmd            command channel (slave side of counter_cmd_seq_if)
//     load_n         to counter, active-low load
//     ce, up_down    to counter, count enable and direction (1 = up)
//     data_load      to counter, load value (holds last loaded value)
//     max_count,zero from counter, status flags
//     busy           command in progress
//     done           one-cycle pulse at command completion
//     steps_done     ce cycles issued by the last/current command
//     sat_hit        valid with done: run stopped early on saturation
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   LOAD  | single cycle with load_n low
//   RUN   | HOLD/UP/DOWN for cmd_len cycles, rem counts down to 1
//   DONE  | done pulse, back to IDLE
module counter_cmd_seq
  import counter_cmd_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_cmd_seq_if.slave cmd,
  output logic             load_n,
  output logic             ce,
  output logic             up_down,
  output logic [WIDTH-1:0] data_load,
  input  logic             max_count,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] steps_done,
  output logic             sat_hit
);

  localparam logic [1:0] ST_IDLE = SEQ_IDLE;
  localparam logic [1:0] ST_LOAD = SEQ_LOAD;
  localparam logic [1:0] ST_RUN  = SEQ_RUN;
  localparam logic [1:0] ST_DONE = SEQ_DONE;

  logic [1:0]       state;
  cmd_op_e          op_q;
  logic [LEN_W-1:0] rem;
  logic             rdy_q;
  logic             accept;
  logic             counting;
  logic             sat_block;
  cmd_op_e          cmd_op_in;

  assign cmd_op_in = cmd_op_e'(cmd.cmd_op);

  // rdy_q keeps cmd_ready low while in reset and for the release edge, so a
  // master holding cmd_valid high never sees a handshake that is not taken.
  assign cmd.cmd_ready = rdy_q && (state == ST_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign counting = (op_q == CMD_UP) || (op_q == CMD_DOWN);

`ifdef SAT_STOP_EN
  // Looks at the flag for the count already in the counter, so the step
  // that would wrap is never issued.
  assign sat_block = ((op_q == CMD_UP) && max_count) ||
                     ((op_q == CMD_DOWN) && zero);
`else
  logic unused_flags;
  assign unused_flags = max_count | zero;
  assign sat_block    = 1'b0;
`endif

  assign ce     = (state == ST_RUN) && counting && !sat_block;
  assign load_n = (state != ST_LOAD);
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= CMD_HOLD;
      rem        <= '0;
      rdy_q      <= 1'b0;
      up_down    <= 1'b0;
      data_load  <= '0;
      steps_done <= '0;
      sat_hit    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= cmd_op_in;
            rem        <= cmd.cmd_len;
            steps_done <= '0;
            sat_hit    <= 1'b0;
            case (cmd_op_in)
              CMD_LOAD: begin
                data_load <= cmd.cmd_data;
                state     <= ST_LOAD;
              end
              CMD_UP, CMD_DOWN: begin
                up_down <= (cmd_op_in == CMD_UP);
                state   <= (cmd.cmd_len == '0) ? ST_DONE : ST_RUN;
              end
              default: begin
                state <= (cmd.cmd_len == '0) ? ST_DONE : ST_RUN;
              end
            endcase
          end
        end
        ST_LOAD: state <= ST_DONE;
        ST_RUN: begin
          if (sat_block) begin
            sat_hit <= 1'b1;
            state   <= ST_DONE;
          end else begin
            rem <= rem - LEN_W'(1);
            if (ce) steps_done <= steps_done + LEN_W'(1);
            if (rem == LEN_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/counter_cmd_seq.md
Name: counter_cmd_seq

Overview:
Command sequencer directly upstream of the up/down loadable counter. Accepts LOAD/UP/DOWN/HOLD commands over a valid/ready handshake and drives the counter's load_n, ce, up_down and data_load pins, one command at a time. Reads the counter's max_count/zero flags back for optional saturating stop. Reports completion with a one-cycle done pulse and an issued-step count.

Parameters:
WIDTH, 4, counter data width (must match the counter's WIDTH from the shared package)
LEN_W, 8, width of the command step-count field

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  00 HOLD, 01 LOAD, 10 UP, 11 DOWN
cmd_data  in  WIDTH  load value (LOAD only)
cmd_len  in  LEN_W  step/cycle count (HOLD/UP/DOWN)
load_n  out  1  to counter, active-low load
ce  out  1  to counter, count enable
up_down  out  1  to counter, 1 = up
data_load  out  WIDTH  to counter, load value
max_count  in  1  from counter, count == all ones
zero  in  1  from counter, count == 0
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
steps_done  out  LEN_W  ce cycles issued by last/current command
sat_hit  out  1  valid with done: run stopped early on saturation

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; load_n=1, ce=0, up_down=0, data_load=0, busy=0, done=0, steps_done=0, sat_hit=0, cmd_ready=1 the cycle after reset is released.
- FSM: IDLE, LOAD, RUN, DONE.
- IDLE: cmd_ready=1. Accept on posedge with cmd_valid&&cmd_ready; capture op/data/len; rem<=cmd_len; steps_done<=0; busy=1 from next cycle. cmd_ready=0 in all non-IDLE states.
- LOAD: exactly one cycle with load_n=0, data_load=cmd_data, ce=0 -> DONE.
- RUN (UP/DOWN): ce=1 for exactly L=cmd_len consecutive cycles, starting the cycle after acceptance; up_down=1 for UP, 0 for DOWN, stable through RUN; steps_done increments per ce cycle. When rem reaches 0 -> DONE.
- RUN (HOLD): same timing with ce=0; models idle gap of L cycles; steps_done stays 0.
- L=0: RUN skipped, accept -> DONE next cycle, no ce pulse.
- DONE: done=1 for one cycle, busy=0 from next cycle; -> IDLE, cmd_ready=1 the cycle after done.
- Outside LOAD, load_n=1; data_load holds last loaded value.
- Counter wrap (F->0 up, 0->F down) is not special without the optional feature.
- Reset mid-command: abort immediately, no done pulse, all outputs to reset values.
- cmd_valid low while idle: outputs static. cmd fields ignored unless accepted.
- Back-to-back: minimum two-cycle gap (DONE, IDLE) between last ce of one command and first control cycle of next.

Optional Feature:
SAT_STOP_EN defined: in RUN-UP, in any cycle where ce would be 1 and max_count=1, ce is forced 0, run ends, -> DONE next cycle with sat_hit=1; symmetric for RUN-DOWN with zero=1. Check is combinational on the current flag, so no wrap is issued. Undefined: flags ignored, counter wraps, sat_hit tied 0 (port kept).

Decomposition:
- Shared package: WIDTH, LEN_W defaults, enum cmd_op_e {HOLD, LOAD, UP, DOWN}, enum seq_state_e {IDLE, LOAD, RUN, DONE}.
- Single module; no sub-module needed. Bench instantiates counter_cmd_seq feeding the counter.

Test Plan:
- Reset for 2 cycles -> all outputs at reset values; cmd_ready=1 one cycle after release.
- LOAD 4'hA -> one cycle load_n=0, data_load=A; counter=A; done pulses next cycle.
- After LOAD A, UP len 3 -> ce high exactly 3 cycles, up_down=1; counter=D; steps_done=3; done once.
- DOWN len 0 -> no ce; done one cycle after accept; steps_done=0.
- LOAD E, UP len 5 -> with SAT_STOP_EN: counter stops at F, steps_done=1, sat_hit=1. Without: counter=3, steps_done=5, sat_hit=0.
- UP len 10 from 0, rst_n=0 after 4 ce cycles -> counter holds 4 (counter not reset); ce=0 and busy=0 next cycle; no done; cmd_valid held high -> next command accepted only when cmd_ready=1.
